// File: rtl/col_readout_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// col_readout_sequencer : BCST broadcast, settle, round-robin column drain
// Rev 1.0
// ============================================================================
module col_readout_sequencer #(
   parameter int BCSTWIDTH = 27,
   parameter int SETTLE    = 8,
   parameter int MAXHITS   = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BCSTWIDTH-1:0]    bcstIn,
   output logic                    busy,
   output logic                    startDropped,
   output logic [BCSTWIDTH*16-1:0] colBCSTChain,
   input  logic [15:0]             colHitChain,
   input  logic [735:0]            colDataChain,
   output logic [15:0]             colReadChain,
   output logic                    doutValid,
   input  logic                    doutReady,
   output logic [51:0]             dout
);

   localparam logic [8:0] c_MAX_HITS    = 9'(MAXHITS);
   localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_BCST, S_SETTLE, S_SCAN, S_TRAIL} state_t;

   state_t               state_q, state_d;
   logic [BCSTWIDTH-1:0] bcst_q, bcst_d;
   logic [7:0]           settleCnt_q, settleCnt_d;
   logic [8:0]           hitCnt_q, hitCnt_d;
   logic                 trunc_q, trunc_d;
   logic                 trailSent_q, trailSent_d;
   logic [3:0]           ptr_q, ptr_d;
   logic                 startDropped_q;
   logic                 doutValid_q;
   logic [51:0]          dout_q;

   logic        w_slotFree;
   logic        w_found;
   logic        w_load;
   logic [3:0]  w_grant;
   logic [3:0]  w_idx;
   logic [51:0] w_word;
   logic [26:0] w_bcstField;

   assign w_slotFree  = !doutValid_q || doutReady;
   assign w_bcstField = 27'(bcst_q);

   // First column with a pending hit, searching upward from the pointer.
   always_comb begin
      w_grant = ptr_q;
      w_found = 1'b0;
      w_idx   = ptr_q;
      for (int k = 0; k < 16; k++) begin
         w_idx = ptr_q + 4'(k);
         if (!w_found && colHitChain[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bcst_d       = bcst_q;
      settleCnt_d  = settleCnt_q;
      hitCnt_d     = hitCnt_q;
      trunc_d      = trunc_q;
      trailSent_d  = trailSent_q;
      ptr_d        = ptr_q;
      w_load       = 1'b0;
      w_word       = '0;
      colReadChain = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bcst_d      = bcstIn;
               settleCnt_d = '0;
               hitCnt_d    = '0;
               trunc_d     = 1'b0;
               trailSent_d = 1'b0;
               state_d     = S_BCST;
            end
         end
         S_BCST: begin
            if (w_slotFree) begin
               w_load      = 1'b1;
               w_word      = {2'b10, w_bcstField, 23'b0};
               settleCnt_d = '0;
               state_d     = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settleCnt_q == c_SETTLE_LAST) begin
               state_d = S_SCAN;
            end else begin
               settleCnt_d = settleCnt_q + 8'd1;
            end
         end
         S_SCAN: begin
            // Truncation only matters if hits are still left behind at the limit.
            if ((colHitChain == 16'h0000) || (hitCnt_q >= c_MAX_HITS)) begin
               trunc_d = (hitCnt_q >= c_MAX_HITS) && (|colHitChain);
               state_d = S_TRAIL;
            end else if (w_slotFree) begin
               colReadChain[w_grant] = 1'b1;
               w_load   = 1'b1;
               w_word   = {2'b01, w_grant, colDataChain[int'(w_grant)*46 +: 46]};
               hitCnt_d = hitCnt_q + 9'd1;
               ptr_d    = w_grant + 4'd1;
            end
         end
         S_TRAIL: begin
            if (!trailSent_q) begin
               if (w_slotFree) begin
                  w_load      = 1'b1;
                  w_word      = {2'b11, hitCnt_q, trunc_q, 40'b0};
                  trailSent_d = 1'b1;
               end
            end else if (doutValid_q && doutReady) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         bcst_q         <= '0;
         settleCnt_q    <= '0;
         hitCnt_q       <= '0;
         trunc_q        <= 1'b0;
         trailSent_q    <= 1'b0;
         ptr_q          <= '0;
         startDropped_q <= 1'b0;
         doutValid_q    <= 1'b0;
         dout_q         <= '0;
      end else begin
         state_q        <= state_d;
         bcst_q         <= bcst_d;
         settleCnt_q    <= settleCnt_d;
         hitCnt_q       <= hitCnt_d;
         trunc_q        <= trunc_d;
         trailSent_q    <= trailSent_d;
         ptr_q          <= ptr_d;
         startDropped_q <= start && (state_q != S_IDLE);
         if (w_load) begin
            dout_q      <= w_word;
            doutValid_q <= 1'b1;
         end else if (doutReady) begin
            doutValid_q <= 1'b0;
         end
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign startDropped = startDropped_q;
   assign colBCSTChain = {16{bcst_q}};
   assign doutValid    = doutValid_q;
   assign dout         = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_col_readout_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_col_readout_sequencer : directed vectors and corner sequences
// Rev 1.0
// ============================================================================
module tb_col_readout_sequencer;

   localparam int c_SETTLE = 8;

   typedef struct {
      int          dut;
      logic [26:0] bcst;
      logic [63:0] hits;   // nibble c = words queued in column c
      logic [63:0] ids;    // nibble k = colID of the k-th data word
      int          ndata;
      logic        trunc;
      logic        bp;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        doutReady;
   logic [26:0] bcstIn;
   logic        startS    [2];
   logic        busyS     [2];
   logic        dropS     [2];
   logic [431:0] chainS   [2];
   logic [15:0] colRdS    [2];
   logic        dvS       [2];
   logic [51:0] doutS     [2];
   logic [15:0] hitChain  [2];
   logic [735:0] dataChain [2];

   int          rd  [2][16];
   int          cnt [2][16];
   logic [45:0] mem [2][16][16];
   logic        mdlClr;

   int          errors = 0;
   int          checks = 0;
   int          onehotViol = 0;
   int          fullPopViol = 0;
   int          stallViol = 0;
   int          popCnt  [2] = '{0, 0};
   int          dropCnt [2] = '{0, 0};
   logic        prevStall [2] = '{1'b0, 1'b0};
   logic [51:0] prevWord  [2];
   logic [51:0] outq0 [$];
   logic [51:0] outq1 [$];

   vec_t        vt [8];

   col_readout_sequencer #(.BCSTWIDTH(27), .SETTLE(c_SETTLE), .MAXHITS(256)) u_dut0 (
      .clk(clk), .reset(reset), .start(startS[0]), .bcstIn(bcstIn),
      .busy(busyS[0]), .startDropped(dropS[0]), .colBCSTChain(chainS[0]),
      .colHitChain(hitChain[0]), .colDataChain(dataChain[0]), .colReadChain(colRdS[0]),
      .doutValid(dvS[0]), .doutReady(doutReady), .dout(doutS[0])
   );

   col_readout_sequencer #(.BCSTWIDTH(27), .SETTLE(c_SETTLE), .MAXHITS(5)) u_dut1 (
      .clk(clk), .reset(reset), .start(startS[1]), .bcstIn(bcstIn),
      .busy(busyS[1]), .startDropped(dropS[1]), .colBCSTChain(chainS[1]),
      .colHitChain(hitChain[1]), .colDataChain(dataChain[1]), .colReadChain(colRdS[1]),
      .doutValid(dvS[1]), .doutReady(doutReady), .dout(doutS[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [45:0] pat(input int d, input int c, input int k);
      return {6'(d + 1), 4'(c), 4'(k), 32'hC0DE0000 ^ 32'(c * 16 + k)};
   endfunction

   // Column FIFO model: head word visible while the hit bit is set.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         hitChain[d]  = '0;
         dataChain[d] = '0;
         for (int c = 0; c < 16; c++) begin
            if (rd[d][c] < cnt[d][c]) begin
               hitChain[d][c]            = 1'b1;
               dataChain[d][46*c +: 46] = mem[d][c][rd[d][c] & 15];
            end
         end
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 16; c++) begin
            if (mdlClr) rd[d][c] <= 0;
            else if (colRdS[d][c] && hitChain[d][c]) rd[d][c] <= rd[d][c] + 1;
         end
      end
   end

   // Protocol monitor and output capture, sampled mid-cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if ($countones(colRdS[d]) > 1) onehotViol++;
         if (colRdS[d] != 16'h0) popCnt[d]++;
         if ((colRdS[d] != 16'h0) && dvS[d] && !doutReady) fullPopViol++;
         if (prevStall[d] && !(dvS[d] && (doutS[d] == prevWord[d]))) stallViol++;
         prevStall[d] = dvS[d] && !doutReady;
         prevWord[d]  = doutS[d];
         if (dropS[d]) dropCnt[d]++;
         if (dvS[d] && doutReady) begin
            if (d == 0) outq0.push_back(doutS[d]);
            else        outq1.push_back(doutS[d]);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic int qsize(input int d);
      return (d == 0) ? outq0.size() : outq1.size();
   endfunction

   function automatic logic [51:0] getw(input int d, input int i);
      if (d == 0) return (i < outq0.size()) ? outq0[i] : 52'h0;
      return (i < outq1.size()) ? outq1[i] : 52'h0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(input int d, input logic [63:0] hits);
      for (int c = 0; c < 16; c++) begin
         cnt[d][c] = int'(hits[4*c +: 4]);
         for (int k = 0; k < 16; k++) mem[d][c][k] = pat(d, c, k);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mdlClr    = 1'b1;
      startS[0] = 1'b0;
      startS[1] = 1'b0;
      doutReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mdlClr = 1'b0;
   endtask

   task automatic pulse_start(input int d, input logic [26:0] b);
      bcstIn    = b;
      startS[d] = 1'b1;
      @(posedge clk);
      #1;
      startS[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d, input bit bp, input string nm);
      int n;
      n = 0;
      while (busyS[d] && (n < 600)) begin
         @(posedge clk);
         #1;
         if (bp) doutReady = ~doutReady;
         n++;
      end
      chk({nm, " event done"}, {63'b0, busyS[d]}, 64'd0);
      doutReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_pop(input int d, input string nm);
      int n;
      n = 0;
      while ((colRdS[d] == 16'h0) && (n < 60)) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, " pop seen"}, {63'b0, colRdS[d] != 16'h0}, 64'd1);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int          base;
      int          pops0;
      int          occ [16];
      logic [3:0]  col;
      logic [51:0] expw;
      do_reset();
      load(v.dut, v.hits);
      base  = qsize(v.dut);
      pops0 = popCnt[v.dut];
      for (int c = 0; c < 16; c++) occ[c] = 0;
      pulse_start(v.dut, v.bcst);
      wait_idle(v.dut, v.bp, $sformatf("v%0d", i));
      chk($sformatf("v%0d word count", i), 64'(qsize(v.dut) - base), 64'(v.ndata + 2));
      chk($sformatf("v%0d header", i), 64'(getw(v.dut, base)), 64'({2'b10, v.bcst, 23'b0}));
      for (int k = 0; k < v.ndata; k++) begin
         col  = v.ids[4*k +: 4];
         expw = {2'b01, col, pat(v.dut, int'(col), occ[col])};
         occ[col]++;
         chk($sformatf("v%0d data%0d", i, k), 64'(getw(v.dut, base + 1 + k)), 64'(expw));
      end
      chk($sformatf("v%0d trailer", i), 64'(getw(v.dut, base + v.ndata + 1)),
          64'({2'b11, 9'(v.ndata), v.trunc, 40'b0}));
      chk($sformatf("v%0d pops", i), 64'(popCnt[v.dut] - pops0), 64'(v.ndata));
   endtask

   initial begin
      int          base;
      int          drop0;
      bit          found;
      logic [26:0] b;

      vt[0] = '{dut:0, bcst:27'h5A5A5A5, hits:64'h0,                   ids:64'h0,      ndata:0, trunc:1'b0, bp:1'b0};
      vt[1] = '{dut:0, bcst:27'h1234567, hits:64'h2000_0000_2000_2000, ids:64'hF73F73, ndata:6, trunc:1'b0, bp:1'b0};
      vt[2] = '{dut:0, bcst:27'h7FFFFFF, hits:64'h3,                   ids:64'h000,    ndata:3, trunc:1'b0, bp:1'b0};
      vt[3] = '{dut:0, bcst:27'h0000001, hits:64'h0100_0000_0000_0020, ids:64'h1E1,    ndata:3, trunc:1'b0, bp:1'b0};
      vt[4] = '{dut:0, bcst:27'h2AAAAAA, hits:64'h0200_0020,           ids:64'h6161,   ndata:4, trunc:1'b0, bp:1'b1};
      vt[5] = '{dut:1, bcst:27'h3C3C3C3, hits:64'h0000_0050_0000_0400, ids:64'h29292,  ndata:5, trunc:1'b1, bp:1'b0};
      vt[6] = '{dut:1, bcst:27'h0F0F0F0, hits:64'h0005_0000,           ids:64'h44444,  ndata:5, trunc:1'b0, bp:1'b0};
      vt[7] = '{dut:1, bcst:27'h0000ABC, hits:64'h33,                  ids:64'h01010,  ndata:5, trunc:1'b1, bp:1'b1};

      bcstIn = '0;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d busy", d), {63'b0, busyS[d]}, 64'd0);
         chk($sformatf("rst%0d startDropped", d), {63'b0, dropS[d]}, 64'd0);
         chk($sformatf("rst%0d doutValid", d), {63'b0, dvS[d]}, 64'd0);
         chk($sformatf("rst%0d dout", d), 64'(doutS[d]), 64'd0);
         chk($sformatf("rst%0d colReadChain", d), 64'(colRdS[d]), 64'd0);
         chk($sformatf("rst%0d colBCSTChain", d), {63'b0, |chainS[d]}, 64'd0);
      end

      for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

      // Start-to-header and start-to-first-pop latency.
      do_reset();
      load(0, 64'h0020_0000);
      b = 27'h155AA33;
      pulse_start(0, b);
      chk("A busy after start", {63'b0, busyS[0]}, 64'd1);
      for (int c = 0; c < 16; c++)
         chk($sformatf("A bcst col%0d", c), 64'(chainS[0][27*c +: 27]), 64'(b));
      chk("A no header at t", {63'b0, dvS[0]}, 64'd0);
      @(posedge clk);
      #1;
      chk("A header valid t+1", {63'b0, dvS[0]}, 64'd1);
      chk("A header word", 64'(doutS[0]), 64'({2'b10, b, 23'b0}));
      for (int k = 2; k <= c_SETTLE + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == c_SETTLE)     chk("A no pop before settle", 64'(colRdS[0]), 64'd0);
         if (k == c_SETTLE + 1) chk("A first pop strobe", 64'(colRdS[0]), 64'h20);
      end
      @(posedge clk);
      #1;
      chk("A data at pop edge", 64'(doutS[0]), 64'({2'b01, 4'd5, pat(0, 5, 0)}));
      wait_idle(0, 1'b0, "A");

      // Start while busy: mid-scan and on the trailer-acceptance edge.
      do_reset();
      load(0, 64'h3000);
      base  = qsize(0);
      drop0 = dropCnt[0];
      b     = 27'h0ABCDEF;
      pulse_start(0, b);
      wait_pop(0, "C");
      pulse_start(0, 27'h7654321);
      chk("C bcst unchanged", 64'(chainS[0][26:0]), 64'(b));
      found = 1'b0;
      for (int n = 0; (n < 200) && !found; n++) begin
         @(negedge clk);
         if (dvS[0] && doutReady && (doutS[0][51:50] == 2'b11)) found = 1'b1;
      end
      chk("C trailer seen", {63'b0, found}, 64'd1);
      if (found) begin
         startS[0] = 1'b1;
         bcstIn    = 27'h1111111;
         @(posedge clk);
         #1;
         startS[0] = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("C idle after drops", {63'b0, busyS[0]}, 64'd0);
      chk("C drop pulses", 64'(dropCnt[0] - drop0), 64'd2);
      chk("C word count", 64'(qsize(0) - base), 64'd5);
      chk("C header", 64'(getw(0, base)), 64'({2'b10, b, 23'b0}));
      chk("C data2", 64'(getw(0, base + 3)), 64'({2'b01, 4'd3, pat(0, 3, 2)}));
      chk("C trailer", 64'(getw(0, base + 4)), 64'({2'b11, 9'd3, 1'b0, 40'b0}));

      // Reset in the middle of a scan, then a clean event.
      do_reset();
      load(0, 64'h0400);
      pulse_start(0, 27'h1111111);
      wait_pop(0, "D");
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("D busy", {63'b0, busyS[0]}, 64'd0);
      chk("D doutValid", {63'b0, dvS[0]}, 64'd0);
      chk("D dout", 64'(doutS[0]), 64'd0);
      chk("D colReadChain", 64'(colRdS[0]), 64'd0);
      chk("D colBCSTChain", {63'b0, |chainS[0]}, 64'd0);
      chk("D startDropped", {63'b0, dropS[0]}, 64'd0);
      do_reset();
      load(0, 64'h0);
      base = qsize(0);
      b    = 27'h5555555;
      pulse_start(0, b);
      @(posedge clk);
      #1;
      chk("D clean header", 64'(doutS[0]), 64'({2'b10, b, 23'b0}));
      wait_idle(0, 1'b0, "D");
      chk("D word count", 64'(qsize(0) - base), 64'd2);
      chk("D trailer", 64'(getw(0, base + 1)), 64'({2'b11, 9'd0, 1'b0, 40'b0}));

      chk("colReadChain one-hot", 64'(onehotViol), 64'd0);
      chk("no pop while slot full", 64'(fullPopViol), 64'd0);
      chk("dout stable while stalled", 64'(stallViol), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/col_readout_sequencer.md
# col_readout_sequencer

Global-side reader for the 16-column pixel readout array: it drives the per-column BCST words and read strobes, and drains the column hit/data chains. On each start pulse it broadcasts the event's BCST word, waits a settle time, then empties all pending column hits round-robin. It emits one framed stream (header, data words, trailer) toward the frame builder and sits between the column array and the global readout.

## Interface
- `BCSTWIDTH`, 27, width of the BCST word per column
- `SETTLE`, 8, cycles from BCST broadcast to first scan (1..255)
- `MAXHITS`, 256, per-event hit limit; hits beyond it are not read (1..511)
- `clk` in 1: 40 MHz clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse requesting an event readout
- `bcstIn` in BCSTWIDTH: event BCST word, sampled with `start`
- `busy` out 1: high from the accepted `start` until the trailer is accepted
- `startDropped` out 1: one-cycle pulse when `start` arrives while `busy`
- `colBCSTChain` out BCSTWIDTH*16: registered `bcstIn` replicated to all 16 columns
- `colHitChain` in 16: column i has a valid word at its head
- `colDataChain` in 736: 46 bits per column, valid while the hit bit is high
- `colReadChain` out 16: one-hot pop strobe
- `doutValid` out 1, `doutReady` in 1: output handshake
- `dout` out 52: framed output word

## Operation
- Column protocol: `colReadChain[i]` high at an edge pops column i. At that edge the column presents its next entry, or drops the hit bit. A column may be popped on consecutive cycles.
- FSM states: IDLE, BCST, SETTLE, SCAN, TRAIL.
  - IDLE: `start` latches `bcstIn` into `colBCSTChain`, clears counters, goes to BCST.
  - BCST: loads the header into the output slot when the slot is free, then goes to SETTLE.
  - SETTLE: counts `SETTLE` cycles, then goes to SCAN.
  - SCAN: pops one column per cycle while the output slot is free. Goes to TRAIL when `colHitChain==0` or the hit count reaches `MAXHITS`.
  - TRAIL: loads the trailer when the slot is free; on its acceptance returns to IDLE.
- Output slot is free when `!doutValid || doutReady`. `colReadChain` is combinational: grant & SCAN & slot free & count<MAXHITS.
- Arbitration is round-robin. The search starts at the column after the last grant (initially column 0) and wraps 15→0.
- Word formats, MSB first:
  - header = {2'b10, bcst[26:0], 23'b0}
  - data = {2'b01, colID[3:0], colData[45:0]}
  - trailer = {2'b11, hitCount[8:0], trunc, 40'b0}
- `hitCount` counts data words emitted; MAXHITS ≤ 511, so it never wraps. `trunc`=1 if SCAN exited at `MAXHITS` while any hit bit was still high.
- `dout`/`doutValid` hold stable while `doutValid && !doutReady`.

## Timing
- Reset values:
  - `busy`=0, `startDropped`=0, `doutValid`=0, `dout`=0
  - `colReadChain`=0, `colBCSTChain`=0
  - FSM=IDLE, round-robin pointer=0
- Reset mid-event aborts the event with no trailer. Outputs take reset values the following cycle.
- `start` at edge t: `colBCSTChain` and `busy` valid after t.
- With `doutReady` held high, the header is valid from t+1. First `colRead` occurs SETTLE+2 cycles after t.
- Pop at edge p: the data word is on `dout` with `doutValid` from p.
- Sustained rate is one data word per cycle with `doutReady` high; backpressure stalls pops with no loss or duplication.
- `start` together with the cycle `busy` falls (trailer accepted) is dropped and pulses `startDropped`.

## Test plan
- Empty event: SETTLE=8, no hits, `start` with bcst=0x5A5A5A5 → header carries 0x5A5A5A5, trailer hitCount=0, trunc=0, no `colRead`.
- Round robin: columns 3, 7, 15 each hold 2 words, ready high → data colIDs in order 3, 7, 15, 3, 7, 15. Trailer hitCount=6. `colReadChain` always one-hot.
- Backpressure: 4 hits, `doutReady` toggling 1010 → 4 data words in order, each held stable while stalled. No pops occur while the slot is full.
- Truncation: MAXHITS=5, 9 hits pending → 5 data words, trailer hitCount=5, trunc=1.
- Start while busy: second `start` mid-SCAN → `startDropped` pulses once; the current event completes unchanged.
- Reset during SCAN → next cycle all outputs zero and FSM IDLE. A new `start` then produces a clean header.
